// File: rtl/sha256_msg_schedule_if.sv
// Bus between the padder/compression side and the SHA-256 message-schedule block.
// The master drives the go level, the padded block and read requests. The slave returns read data and ready.
interface sha256_msg_schedule_if;
    logic         local_go_sig;
    logic [511:0] pad_reg;
    logic         w_reg_read;
    logic [5:0]   w_reg_addr;
    logic         regop_w_reg_rdy;
    logic [31:0]  regop_w_reg_data;

    modport master (
        output local_go_sig, pad_reg, w_reg_read, w_reg_addr,
        input  regop_w_reg_rdy, regop_w_reg_data
    );

    modport slave (
        input  local_go_sig, pad_reg, w_reg_read, w_reg_addr,
        output regop_w_reg_rdy, regop_w_reg_data
    );
endinterface

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads W0..W15 from a padded block, then expands W16..W63 at one word per cycle.
// Optional macro WSCHED_READ_GUARD_EN: read data is zeroed while not reading or while the words are not ready.
module sha256_msg_schedule (
    input  logic                        clock,
    input  logic                        reset,
    sha256_msg_schedule_if.slave        bus
);
    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t      state, state_next;
    logic [5:0]  t;
    logic [31:0] w [64];
    logic [31:0] w_new;
    logic        load, write, set_rdy, clr_rdy;

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    // The subtractions wrap in 6 bits, but t never drops below 16 while the result is used.
    always_comb begin
        w_new = sigma1(w[t - 6'd2]) + w[t - 6'd7] + sigma0(w[t - 6'd15]) + w[t - 6'd16];
    end

    // NOTE: every output of this block is given a default first, so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        write      = 1'b0;
        set_rdy    = 1'b0;
        clr_rdy    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.local_go_sig) begin
                    load       = 1'b1;
                    state_next = COMPUTE;
                end
            end
            COMPUTE: begin
                write = 1'b1;
                if (t == 6'd63) begin
                    set_rdy    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (!bus.local_go_sig) begin
                    clr_rdy    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments, so every register samples values from before the edge.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: the word array is reset explicitly because a reset must leave every word at zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            t                   <= 6'd0;
            bus.regop_w_reg_rdy <= 1'b0;
            for (int i = 0; i < 64; i++) w[i] <= 32'd0;
        end else begin
            if (load) begin
                for (int i = 0; i < 16; i++) w[i] <= bus.pad_reg[511 - 32*i -: 32];
                t <= 6'd16;
            end
            if (write) begin
                w[t] <= w_new;
                t    <= t + 6'd1;
            end
            if (set_rdy)      bus.regop_w_reg_rdy <= 1'b1;
            else if (clr_rdy) bus.regop_w_reg_rdy <= 1'b0;
        end
    end

    // A read that hits the word written in the same cycle returns the pre-edge value.
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.regop_w_reg_data <= 32'd0;
        end else begin
`ifdef WSCHED_READ_GUARD_EN
            if (bus.w_reg_read && bus.regop_w_reg_rdy) bus.regop_w_reg_data <= w[bus.w_reg_addr];
            else                                       bus.regop_w_reg_data <= 32'd0;
`else
            if (bus.w_reg_read) bus.regop_w_reg_data <= w[bus.w_reg_addr];
`endif
        end
    end
endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for sha256_msg_schedule: covers reset, the "abc" expansion, sequential reads,
// go toggling during expansion, restart with a new block, and reset during expansion.
module tb_sha256_msg_schedule;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    sha256_msg_schedule_if bus ();

    sha256_msg_schedule dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0]  exp_w [64];
    logic [511:0] abc_blk;
    logic [511:0] ff_blk;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Reference SHA-256 schedule built from shifts and ORs.
    function automatic logic [31:0] ref_s0(input logic [31:0] x);
        return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ref_s1(input logic [31:0] x);
        return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
    endfunction

    task automatic build_model(input logic [511:0] blk);
        for (int i = 0; i < 16; i++) exp_w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++)
            exp_w[i] = ref_s1(exp_w[i-2]) + exp_w[i-7] + ref_s0(exp_w[i-15]) + exp_w[i-16];
    endtask

    task automatic read_word(input int a, input string tag, input logic [31:0] exp_v);
        bus.w_reg_addr = a[5:0];
        bus.w_reg_read = 1'b1;
        tick();
        check(tag, bus.regop_w_reg_data, exp_v);
    endtask

    // Counts edges after the go edge until ready rises, with an upper bound; optionally toggles go mid-expansion.
    task automatic wait_rdy(input int already, input bit toggle_go, input string tag);
        int n;
        n = already;
        while (!bus.regop_w_reg_rdy && n < 100) begin
            if (toggle_go && n == 10) bus.local_go_sig = 1'b0;
            if (toggle_go && n == 13) bus.local_go_sig = 1'b1;
            tick();
            n++;
        end
        check(tag, 32'(n), 32'd48);
    endtask

    initial begin
        abc_blk = '0;
        abc_blk[511:480] = 32'h61626380;
        abc_blk[31:0]    = 32'h00000018;
        ff_blk  = '1;

        // Reset
        reset = 1'b1;
        bus.local_go_sig = 1'b0;
        bus.pad_reg      = '0;
        bus.w_reg_read   = 1'b1;
        bus.w_reg_addr   = 6'd5;
        tick();
        tick();
        check("reset_rdy", {31'b0, bus.regop_w_reg_rdy}, 32'd0);
        check("reset_data", bus.regop_w_reg_data, 32'h0);
        reset = 1'b0;
        tick();
        check("post_reset_w5", bus.regop_w_reg_data, 32'h0);
        check("post_reset_rdy", {31'b0, bus.regop_w_reg_rdy}, 32'd0);

        // "abc" block with go held high
        build_model(abc_blk);
        bus.pad_reg      = abc_blk;
        bus.local_go_sig = 1'b1;
        bus.w_reg_read   = 1'b0;
        tick();
        check("abc_rdy_low_at_go", {31'b0, bus.regop_w_reg_rdy}, 32'd0);
        wait_rdy(0, 1'b0, "abc_rdy_latency");
        read_word(16, "abc_w16", 32'h61626380);
        read_word(17, "abc_w17", 32'h000F0000);

        // Sequential read with a hold at address 61
        for (int a = 0; a < 64; a++) begin
            bus.w_reg_addr = a[5:0];
            for (int r = 0; r < ((a == 61) ? 5 : 1); r++) begin
                tick();
                check($sformatf("seq_w%0d_%0d", a, r), bus.regop_w_reg_data, exp_w[a]);
            end
        end
        check("abc_rdy_held", {31'b0, bus.regop_w_reg_rdy}, 32'd1);

        // Restart: drop go, then raise it with an all-ones block and toggle go mid-expansion
        bus.w_reg_read   = 1'b0;
        bus.local_go_sig = 1'b0;
        tick();
        check("restart_rdy_clear", {31'b0, bus.regop_w_reg_rdy}, 32'd0);
        tick();
        bus.pad_reg      = ff_blk;
        bus.local_go_sig = 1'b1;
        bus.w_reg_read   = 1'b1;
        bus.w_reg_addr   = 6'd16;
        tick();
        check("restart_rdy_low_at_go", {31'b0, bus.regop_w_reg_rdy}, 32'd0);
        tick();
        check("read_during_write_old", bus.regop_w_reg_data, 32'h61626380);
        bus.w_reg_read = 1'b0;
        wait_rdy(1, 1'b1, "ff_rdy_latency");
        build_model(ff_blk);
        read_word(16, "ff_w16", 32'h203FFFFC);
        read_word(0,  "ff_w0",  exp_w[0]);
        read_word(15, "ff_w15", exp_w[15]);
        read_word(40, "ff_w40", exp_w[40]);
        read_word(63, "ff_w63", exp_w[63]);

        // Reset in the middle of an expansion
        bus.w_reg_read   = 1'b0;
        bus.local_go_sig = 1'b0;
        tick();
        build_model(abc_blk);
        bus.pad_reg      = abc_blk;
        bus.local_go_sig = 1'b1;
        tick();
        for (int i = 0; i < 14; i++) tick();
        reset            = 1'b1;
        bus.local_go_sig = 1'b0;
        tick();
        reset = 1'b0;
        check("midreset_rdy", {31'b0, bus.regop_w_reg_rdy}, 32'd0);
        read_word(0,  "midreset_w0",  32'h0);
        read_word(15, "midreset_w15", 32'h0);
        read_word(20, "midreset_w20", 32'h0);
        bus.w_reg_read = 1'b0;
        for (int i = 0; i < 50; i++) tick();
        check("midreset_stays_idle", {31'b0, bus.regop_w_reg_rdy}, 32'd0);
        bus.local_go_sig = 1'b1;
        tick();
        wait_rdy(0, 1'b0, "reload_rdy_latency");
        read_word(0,  "reload_w0",  exp_w[0]);
        read_word(16, "reload_w16", 32'h61626380);
        read_word(17, "reload_w17", 32'h000F0000);
        read_word(40, "reload_w40", exp_w[40]);
        read_word(63, "reload_w63", exp_w[63]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sha256_msg_schedule.md
# sha256_msg_schedule

SHA-256 message-schedule generator. It takes one 512-bit padded block and expands it into the 64 schedule words W0..W63, one word per cycle after the initial load. The words are kept in an internal 64×32 register file that downstream compression logic reads by address. It sits between the padded-block generator (driving `local_go_sig` and `pad_reg`) and the compression round logic.

## Interface
- No parameters; all widths fixed by SHA-256.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `local_go_sig` in 1: start/hold level from the padder; sampled high in IDLE starts expansion.
- `pad_reg` in 512: padded block. Big-endian: W0 = `pad_reg[511:480]`, W15 = `pad_reg[31:0]`.
- `w_reg_read` in 1: read strobe.
- `w_reg_addr` in 6: word index 0..63 to read.
- `regop_w_reg_rdy` out 1: registered; high while all 64 words are valid.
- `regop_w_reg_data` out 32: registered read data.

## Operation
- States: IDLE, COMPUTE, DONE. Internal index `t` is 6 bits.
- **IDLE**
  - If `local_go_sig` = 1: copy W0..W15 from `pad_reg`, set t = 16, go to COMPUTE.
  - Otherwise stay in IDLE.
- **COMPUTE**, one word per cycle:
  - W[t] = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16], modulo 2^32 (carries discarded).
  - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - t increments after each word. When W63 is written, set `regop_w_reg_rdy` = 1 and go to DONE.
  - `local_go_sig` is ignored in COMPUTE.
- **DONE**
  - Hold `regop_w_reg_rdy` = 1 and keep array contents while `local_go_sig` = 1.
  - When `local_go_sig` = 0: clear `regop_w_reg_rdy` and go to IDLE. Array contents are retained.
  - A later go in IDLE reloads the array from the current `pad_reg`.
- **Read**
  - With `w_reg_read` = 1, `regop_w_reg_data` <= W[`w_reg_addr`] at the next edge.
  - With `w_reg_read` = 0, `regop_w_reg_data` holds its value.
  - All 64 addresses are valid; there is no out-of-range case.
  - Reading during COMPUTE returns the current array contents (stale or partial words).
- **Reset**
  - State = IDLE, t = 0, `regop_w_reg_rdy` = 0, `regop_w_reg_data` = 0, all W = 0.
  - Reset mid-COMPUTE aborts the expansion.

## Timing
- Go sampled at edge k (IDLE):
  - W0..W15 are valid after edge k.
  - W16..W63 are written at edges k+1..k+48.
  - `regop_w_reg_rdy` rises after edge k+48, concurrent with the W63 write.
- Read latency is 1 cycle: address presented before edge n gives data after edge n. Back-to-back reads give one word per cycle.
- Read and compute in the same cycle are independent. A read of the index being written that cycle returns the old value.
- `regop_w_reg_rdy` falls one edge after `local_go_sig` is sampled low in DONE.

## Configuration
- `WSCHED_READ_GUARD_EN` defined:
  - A read with `regop_w_reg_rdy` = 0 loads `regop_w_reg_data` = 0.
  - With `w_reg_read` = 0, `regop_w_reg_data` is forced to 0.
- `WSCHED_READ_GUARD_EN` undefined: read behaviour is exactly as in Operation (ungated, hold when not reading).

## Test plan
- **Reset:** reset high for 2 cycles, read address 5 -> `regop_w_reg_rdy` = 0, `regop_w_reg_data` = 0x00000000.
- **"abc" block:** W0 = 0x61626380, W1..W14 = 0, W15 = 0x00000018, go held high ->
  - `regop_w_reg_rdy` rises exactly 48 edges after the go edge.
  - Reads return W16 = 0x61626380 and W17 = 0x000F0000.
  - W0..W63 match a software SHA-256 model.
- **Sequential read:** `w_reg_read` = 1, address 0..63 one per cycle, with a 5-cycle hold at address 61 -> each word appears one cycle after its address; data stays W61 during the hold.
- **Go ignored in COMPUTE:** toggle `local_go_sig` low then high mid-COMPUTE -> expansion completes unchanged and rdy timing is unaffected.
- **Restart:** drop go in DONE, then raise it with a new `pad_reg` (all 0xFF..FF) ->
  - rdy clears.
  - The new expansion completes after 48 cycles with W16 = σ1(0xFFFFFFFF) + 0xFFFFFFFF + σ0(0xFFFFFFFF) + 0xFFFFFFFF mod 2^32.
- **Reset mid-COMPUTE:** assert reset at t = 30 -> state IDLE, rdy = 0, array zeroed; a following go restarts from the load.
